te_block_sequencer: RTL and testbench
=====================================

# te_block_sequencer

Serialises the up-to-N parallel trace blocks produced each cycle by the multiple-retirement stage into a single block-per-cycle stream for the trace encoder, using a valid/ready handshake. It buffers blocks in a circular queue and raises a registered stall toward the retirement stage when little space is left. It drops whole input cycles on overflow and counts them, so encoder back-pressure never corrupts block order.

## Interface
Parameters:
- N, 2, max blocks presented per cycle (lanes); ≥1
- DEPTH, 8, queue entries; power of two, ≥ 2*N
- CNT_W, 16, width of the drop counter

Ports (widths from mure_pkg):
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous queue clear
- valid_i  in  N  per-lane block valid
- iretire_i  in  N×IRETIRE_LEN  per-lane retired halfword count
- ilastsize_i  in  N  per-lane last-instruction size
- itype_i  in  N×ITYPE_LEN  per-lane itype
- iaddr_i  in  N×XLEN  per-lane block address
- cause_i  in  CAUSE_LEN  cause, meaningful only for lane 0
- tval_i  in  XLEN  tval, meaningful only for lane 0
- priv_i  in  PRIV_LEN  privilege, shared by all lanes this cycle
- out_valid_o  out  1  head block valid
- out_ready_i  in  1  encoder accepts head block
- iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o  out  single-block widths  head block fields
- stall_o  out  1  request retirement stage to hold
- overflow_o  out  1  sticky overflow flag
- drop_cnt_o  out  CNT_W  number of dropped input cycles
- clr_stats_i  in  1  clears overflow_o and drop_cnt_o

## Operation
- Storage: DEPTH-entry circular buffer. Each entry holds {iretire, ilastsize, itype, iaddr, cause, tval, priv}. Read/write pointers have width log2(DEPTH) and wrap modulo DEPTH. Occupancy count_q has width log2(DEPTH)+1.
- Push: k = popcount(valid_i). Valid lanes are written in ascending lane order to consecutive slots starting at wr_ptr. Invalid lanes are skipped, so gaps are compacted. cause/tval are stored from the inputs when lane 0's entry has itype 1 or 2; otherwise they are stored as 0. priv_i is copied into every pushed entry.
- Admission is all-or-nothing. A cycle is accepted iff k ≤ DEPTH − count_q, using count_q at cycle start; a same-cycle pop gives no credit. Otherwise:
  - none of the lanes are written;
  - drop_cnt increments by 1 and saturates at all-ones;
  - overflow_o sets.
- k = 0 is a no-op.
- Pop: the head entry drives the outputs combinationally from storage. out_valid_o = (count_q ≠ 0). A pop occurs when out_valid_o && out_ready_i. Output fields may be X-free garbage when out_valid_o = 0; they are held at 0 in reset.
- Count update: count_d = count_q + (accepted ? k : 0) − pop.
- stall_o is a register: stall_q ≤ (count_d > DEPTH − 2*N).
- flush_i: pointers and count go to 0 next cycle; a push or pop in the same cycle is ignored. stall_o follows the new count. Stats are unaffected.
- clr_stats_i: overflow and drop_cnt go to 0 next cycle. A simultaneous drop wins: drop_cnt = 1 and overflow = 1.

## Timing
- Reset values: out_valid_o 0, all output fields 0, stall_o 0, overflow_o 0, drop_cnt_o 0; pointers and count 0.
- Latency: a block pushed in cycle t is visible at the output in cycle t+1 at the earliest (from an empty queue).
- Throughput: one pop per cycle. A block is held stable while out_valid_o && !out_ready_i.
- Full queue plus push of k ≤ 1 in the same cycle as a pop: the push is rejected, because there is no same-cycle credit.
- Reset mid-operation clears all state immediately (asynchronous). Deasserting reset takes effect on the next clk_i edge.

## Test plan
- Single block: lane 0 valid, itype=2, cause=5, tval=0xDEAD, out_ready_i=1 → next cycle out_valid_o=1 with itype 2, cause 5, tval 0xDEAD; following cycle out_valid_o=0.
- Lane compaction and order: N=2. Cycle 0 valid=2'b11 with iaddr 0x100/0x200; cycle 1 valid=2'b10 with iaddr 0x300 → output order 0x100, 0x200, 0x300; the lane-1 entry of cycle 1 has cause=0.
- Back-pressure and stall: DEPTH=8, N=2, out_ready_i=0, valid=2'b11 every cycle → stall_o=1 one cycle after count reaches 6. The cycle with count=8 and k=2 is rejected: drop_cnt_o=1, overflow_o=1, count stays 8.
- Full plus simultaneous pop: count=8, out_ready_i=1, valid=2'b01 → push rejected, count becomes 7, drop_cnt increments.
- Flush and clear: 5 entries queued, pulse flush_i → out_valid_o=0 next cycle with stats kept. Then pulse clr_stats_i → overflow_o=0, drop_cnt_o=0.
- Async reset mid-stream: assert rst_ni=0 with 4 entries queued → all outputs 0 immediately. After release, the queue is empty and accepts a fresh push.

Source files
------------

// File: rtl/te_block_sequencer.sv
// rtl/te_block_sequencer.sv - serialises up to N trace blocks per cycle into a one-block-per-cycle stream
module te_block_sequencer #(
  parameter int unsigned N           = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned IRETIRE_LEN = 7,
  parameter int unsigned ITYPE_LEN   = 3,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CAUSE_LEN   = 5,
  parameter int unsigned PRIV_LEN    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [N-1:0]               valid_i,
  input  logic [N*IRETIRE_LEN-1:0]   iretire_i,
  input  logic [N-1:0]               ilastsize_i,
  input  logic [N*ITYPE_LEN-1:0]     itype_i,
  input  logic [N*XLEN-1:0]          iaddr_i,
  input  logic [CAUSE_LEN-1:0]       cause_i,
  input  logic [XLEN-1:0]            tval_i,
  input  logic [PRIV_LEN-1:0]        priv_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [IRETIRE_LEN-1:0]     iretire_o,
  output logic                       ilastsize_o,
  output logic [ITYPE_LEN-1:0]       itype_o,
  output logic [XLEN-1:0]            iaddr_o,
  output logic [CAUSE_LEN-1:0]       cause_o,
  output logic [XLEN-1:0]            tval_o,
  output logic [PRIV_LEN-1:0]        priv_o,
  output logic                       stall_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  input  logic                       clr_stats_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IRETIRE_LEN-1:0] mem_iretire   [DEPTH];
  logic                   mem_ilastsize [DEPTH];
  logic [ITYPE_LEN-1:0]   mem_itype     [DEPTH];
  logic [XLEN-1:0]        mem_iaddr     [DEPTH];
  logic [CAUSE_LEN-1:0]   mem_cause     [DEPTH];
  logic [XLEN-1:0]        mem_tval      [DEPTH];
  logic [PRIV_LEN-1:0]    mem_priv      [DEPTH];

  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             stall_q, overflow_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic [CW-1:0] k, free;
  logic [AW-1:0] slot [N];
  logic          accept, drop, pop, keep_ct;
  logic [ITYPE_LEN-1:0] itype0;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it,
  // which compacts gaps while preserving lane order.
  always_comb begin
    k = '0;
    for (int i = 0; i < int'(N); i++) begin
      slot[i] = wr_ptr_q + k[AW-1:0];
      k       = k + CW'(valid_i[i]);
    end
    free    = CW'(DEPTH) - count_q;
    accept  = !flush_i && (k != '0) && (k <= free);
    drop    = !flush_i && (k != '0) && (k > free);
    pop     = !flush_i && out_valid_o && out_ready_i;
    itype0  = itype_i[ITYPE_LEN-1:0];
    keep_ct = valid_i[0] && ((itype0 == ITYPE_LEN'(1)) || (itype0 == ITYPE_LEN'(2)));
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + (accept ? k : '0) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int d = 0; d < int'(DEPTH); d++) begin
        mem_iretire[d]   <= '0;
        mem_ilastsize[d] <= 1'b0;
        mem_itype[d]     <= '0;
        mem_iaddr[d]     <= '0;
        mem_cause[d]     <= '0;
        mem_tval[d]      <= '0;
        mem_priv[d]      <= '0;
      end
    end else begin
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (accept) begin
          for (int i = 0; i < int'(N); i++) begin
            if (valid_i[i]) begin
              mem_iretire[slot[i]]   <= iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
              mem_ilastsize[slot[i]] <= ilastsize_i[i];
              mem_itype[slot[i]]     <= itype_i[i*ITYPE_LEN +: ITYPE_LEN];
              mem_iaddr[slot[i]]     <= iaddr_i[i*XLEN +: XLEN];
              mem_cause[slot[i]]     <= (i == 0 && keep_ct) ? cause_i : '0;
              mem_tval[slot[i]]      <= (i == 0 && keep_ct) ? tval_i : '0;
              mem_priv[slot[i]]      <= priv_i;
            end
          end
          wr_ptr_q <= wr_ptr_q + k[AW-1:0];
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
      count_q <= count_d;
      stall_q <= (count_d > CW'(DEPTH - 2*N));
      // A drop in the same cycle as a stats clear is still recorded.
      if (drop) begin
        overflow_q <= 1'b1;
        if (clr_stats_i) begin
          drop_cnt_q <= CNT_W'(1);
        end else if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
      end else if (clr_stats_i) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end
    end
  end

  assign out_valid_o = (count_q != '0);
  assign iretire_o   = mem_iretire[rd_ptr_q];
  assign ilastsize_o = mem_ilastsize[rd_ptr_q];
  assign itype_o     = mem_itype[rd_ptr_q];
  assign iaddr_o     = mem_iaddr[rd_ptr_q];
  assign cause_o     = mem_cause[rd_ptr_q];
  assign tval_o      = mem_tval[rd_ptr_q];
  assign priv_o      = mem_priv[rd_ptr_q];
  assign stall_o     = stall_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_te_block_sequencer.sv
// tb/tb_te_block_sequencer.sv - directed and randomized checks of te_block_sequencer against a queue model
module tb_te_block_sequencer;

  localparam int N = 2, DEPTH = 8, CNT_W = 16;
  localparam int IRL = 7, ITL = 3, XL = 32, CL = 5, PL = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, clr, out_ready;
  logic [N-1:0]    valid;
  logic [N*IRL-1:0] iretire;
  logic [N-1:0]    ilastsize;
  logic [N*ITL-1:0] itype;
  logic [N*XL-1:0] iaddr;
  logic [CL-1:0]   cause;
  logic [XL-1:0]   tval;
  logic [PL-1:0]   priv;
  logic            out_valid, stall, overflow, ilastsize_out;
  logic [IRL-1:0]  iretire_out;
  logic [ITL-1:0]  itype_out;
  logic [XL-1:0]   iaddr_out, tval_out;
  logic [CL-1:0]   cause_out;
  logic [PL-1:0]   priv_out;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  te_block_sequencer #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W), .IRETIRE_LEN(IRL),
                       .ITYPE_LEN(ITL), .XLEN(XL), .CAUSE_LEN(CL), .PRIV_LEN(PL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid),
    .iretire_i(iretire), .ilastsize_i(ilastsize), .itype_i(itype), .iaddr_i(iaddr),
    .cause_i(cause), .tval_i(tval), .priv_i(priv),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .iretire_o(iretire_out), .ilastsize_o(ilastsize_out), .itype_o(itype_out),
    .iaddr_o(iaddr_out), .cause_o(cause_out), .tval_o(tval_out), .priv_o(priv_out),
    .stall_o(stall), .overflow_o(overflow), .drop_cnt_o(drop_cnt), .clr_stats_i(clr)
  );

  typedef struct {
    logic [IRL-1:0] iretire;
    logic           ilastsize;
    logic [ITL-1:0] itype;
    logic [XL-1:0]  iaddr;
    logic [CL-1:0]  cause;
    logic [XL-1:0]  tval;
    logic [PL-1:0]  priv;
  } ent_t;

  ent_t mq[$];
  int   m_drop = 0;
  bit   m_ov = 0, m_stall = 0;
  int   nvec = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("iretire", 64'(iretire_out), 64'(mq[0].iretire));
      chk("ilastsize", 64'(ilastsize_out), 64'(mq[0].ilastsize));
      chk("itype", 64'(itype_out), 64'(mq[0].itype));
      chk("iaddr", 64'(iaddr_out), 64'(mq[0].iaddr));
      chk("cause", 64'(cause_out), 64'(mq[0].cause));
      chk("tval", 64'(tval_out), 64'(mq[0].tval));
      chk("priv", 64'(priv_out), 64'(mq[0].priv));
    end
    chk("stall", 64'(stall), 64'(m_stall));
    chk("overflow", 64'(overflow), 64'(m_ov));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_iaddr"}, 64'(iaddr_out), 64'd0);
    chk({tag, "_itype"}, 64'(itype_out), 64'd0);
    chk({tag, "_cause"}, 64'(cause_out), 64'd0);
    chk({tag, "_tval"}, 64'(tval_out), 64'd0);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  task automatic model_clear();
    mq.delete();
    m_drop = 0;
    m_ov = 0;
    m_stall = 0;
  endtask

  // Apply the current inputs for one clock, advancing the model by the admission rules.
  task automatic step();
    int   k;
    bit   do_pop, dropped;
    ent_t e;
    k = $countones(valid);
    dropped = 0;
    if (flush) begin
      mq.delete();
    end else begin
      do_pop = (mq.size() != 0) && out_ready;
      if (k != 0 && k > DEPTH - mq.size()) dropped = 1;
      if (do_pop) void'(mq.pop_front());
      if (k != 0 && !dropped) begin
        for (int i = 0; i < N; i++) begin
          if (valid[i]) begin
            e.iretire   = iretire[i*IRL +: IRL];
            e.ilastsize = ilastsize[i];
            e.itype     = itype[i*ITL +: ITL];
            e.iaddr     = iaddr[i*XL +: XL];
            e.priv      = priv;
            if (i == 0 && (e.itype == 1 || e.itype == 2)) begin
              e.cause = cause;
              e.tval  = tval;
            end else begin
              e.cause = '0;
              e.tval  = '0;
            end
            mq.push_back(e);
          end
        end
      end
    end
    if (dropped) begin
      m_ov = 1;
      m_drop = clr ? 1 : (m_drop == 65535 ? 65535 : m_drop + 1);
    end else if (clr) begin
      m_ov = 0;
      m_drop = 0;
    end
    m_stall = (mq.size() > DEPTH - 2 * N);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    flush = 0; clr = 0; valid = '0; out_ready = 0;
    iretire = '0; ilastsize = '0; itype = '0; iaddr = '0;
    cause = '0; tval = '0; priv = '0;
  endtask

  task automatic randomize_fields();
    iretire   = N*IRL'($urandom);
    ilastsize = N'($urandom);
    itype     = N*ITL'($urandom);
    iaddr     = {$urandom, $urandom};
    cause     = CL'($urandom);
    tval      = $urandom;
    priv      = PL'($urandom);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #12;
    check_zero("reset");
    #10;
    rst_n = 1;
    model_clear();

    // Single block with cause/tval kept because itype is 2.
    out_ready = 1;
    valid = 2'b01;
    itype = {3'd0, 3'd2};
    cause = 5'd5;
    tval = 32'hDEAD;
    iaddr = {32'h0, 32'h40};
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_itype", 64'(itype_out), 64'd2);
    chk("single_cause", 64'(cause_out), 64'd5);
    chk("single_tval", 64'(tval_out), 64'hDEAD);
    valid = '0;
    step();
    chk("single_drain", 64'(out_valid), 64'd0);

    // Compaction: lane 1 alone must follow the two-lane cycle and carry no cause.
    out_ready = 0;
    valid = 2'b11;
    iaddr = {32'h200, 32'h100};
    itype = {3'd1, 3'd1};
    step();
    valid = 2'b10;
    iaddr = {32'h300, 32'h0};
    step();
    valid = '0;
    out_ready = 1;
    step();
    step();
    chk("compact_third", 64'(iaddr_out), 64'h300);
    chk("compact_cause0", 64'(cause_out), 64'd0);
    step();

    // Fill with back-pressure until a whole cycle is rejected.
    out_ready = 0;
    valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      randomize_fields();
      step();
    end
    chk("full_drop", 64'(drop_cnt), 64'd1);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_stall", 64'(stall), 64'd1);

    // Full queue with a simultaneous pop still rejects a one-lane push.
    out_ready = 1;
    valid = 2'b01;
    step();
    chk("pop_nocredit_drop", 64'(drop_cnt), 64'd2);
    chk("pop_nocredit_cnt", 64'(mq.size()), 64'd7);

    // Flush a five-entry queue; stats survive until cleared.
    valid = '0;
    flush = 1;
    step();
    flush = 0;
    out_ready = 0;
    valid = 2'b11;
    step();
    step();
    valid = 2'b01;
    step();
    valid = '0;
    flush = 1;
    step();
    flush = 0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_keeps_drop", 64'(drop_cnt), 64'd2);
    clr = 1;
    step();
    clr = 0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    // Asynchronous reset with four entries queued.
    valid = 2'b11;
    randomize_fields();
    step();
    randomize_fields();
    step();
    valid = '0;
    #3;
    rst_n = 0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #2;
    rst_n = 1;
    model_clear();
    valid = 2'b01;
    randomize_fields();
    step();
    chk("post_rst_push", 64'(out_valid), 64'd1);
    valid = '0;
    out_ready = 1;
    step();

    // Randomized traffic in phases of varying encoder back-pressure.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 250; c++) begin
        randomize_fields();
        valid = N'($urandom);
        out_ready = ($urandom_range(0, 5) < ph) ? 1'b1 : 1'b0;
        flush = ($urandom_range(0, 63) == 0);
        if (flush) valid = '0;
        clr = ($urandom_range(0, 47) == 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
